// File: rtl/cache_bus_arbiter_if.sv
// Bundle of the I$/D$ request/ack signals and the shared line-bus port
// that cache_bus_arbiter multiplexes between the two caches.
interface cache_bus_arbiter_if #(
  parameter int PA_BITS = 34
);
  logic [1:0]         ICacheBusRW;
  logic [PA_BITS-1:0] ICacheBusAdr;
  logic               ICacheBusAck;
  logic [1:0]         DCacheBusRW;
  logic [PA_BITS-1:0] DCacheBusAdr;
  logic               DCacheBusAck;
  logic [1:0]         BusRW;
  logic [PA_BITS-1:0] BusAdr;
  logic               BusAck;
  logic               GrantI;
  logic               GrantD;
  logic               ArbConflict;

  modport slave (
    input  ICacheBusRW, ICacheBusAdr, DCacheBusRW, DCacheBusAdr, BusAck,
    output ICacheBusAck, DCacheBusAck, BusRW, BusAdr, GrantI, GrantD, ArbConflict
  );

  modport master (
    output ICacheBusRW, ICacheBusAdr, DCacheBusRW, DCacheBusAdr, BusAck,
    input  ICacheBusAck, DCacheBusAck, BusRW, BusAdr, GrantI, GrantD, ArbConflict
  );
endinterface

// File: rtl/cache_bus_arbiter.sv
// Shares one line-granular bus port between I$ and D$: fixed priority with a
// starvation bound, grant held for a whole line transfer, ack routed to owner.
module cache_bus_arbiter #(
  parameter int PA_BITS = 34,
  parameter bit DPRIO   = 1'b1,
  parameter int MAXWAIT = 4
) (
  input logic               clk,
  input logic               reset,
  cache_bus_arbiter_if.slave bus
);

  localparam int            CW     = $clog2(MAXWAIT + 1);
  localparam logic [CW-1:0] MAXW_C = CW'(MAXWAIT);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_I = 2'b01,
    BUSY_D = 2'b10
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [1:0]         r_rw;
  logic [PA_BITS-1:0] r_adr;
  logic [CW-1:0]      r_cnt;
  logic [CW-1:0]      w_next_cnt;
  logic               w_req_i;
  logic               w_req_d;
  logic               w_force;
  logic               w_conflict;
  logic               w_grant_i;
  logic               w_grant_d;
  logic               w_ack_i;
  logic               w_ack_d;

  assign w_req_i = |bus.ICacheBusRW;
  assign w_req_d = |bus.DCacheBusRW;
  // r_cnt counts how often the non-priority side has lost; at the limit it wins
  assign w_force = (r_cnt == MAXW_C);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state, starvation-count and grant/ack decode
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_conflict   = 1'b0;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    w_ack_i      = 1'b0;
    w_ack_d      = 1'b0;
    case (r_state)
      IDLE: begin
        w_conflict = w_req_i && w_req_d;
        w_next_cnt = {CW{1'b0}};
        if (w_req_i && w_req_d) begin
          if (w_force) begin
            w_next_state = DPRIO ? BUSY_I : BUSY_D;
          end else begin
            w_next_state = DPRIO ? BUSY_D : BUSY_I;
            w_next_cnt   = r_cnt + CW'(1);
          end
        end else if (w_req_i) begin
          w_next_state = BUSY_I;
        end else if (w_req_d) begin
          w_next_state = BUSY_D;
        end else begin
          w_next_state = IDLE;
        end
      end
      BUSY_I: begin
        w_grant_i = 1'b1;
        w_ack_i   = bus.BusAck;
        if (bus.BusAck) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = BUSY_I;
        end
      end
      BUSY_D: begin
        w_grant_d = 1'b1;
        w_ack_d   = bus.BusAck;
        if (bus.BusAck) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = BUSY_D;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_next_cnt   = {CW{1'b0}};
      end
    endcase
  end

  // Latched request and starvation counter; request is frozen for the whole transfer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rw  <= 2'b00;
      r_adr <= {PA_BITS{1'b0}};
      r_cnt <= {CW{1'b0}};
    end else begin
      r_cnt <= w_next_cnt;
      if (r_state == IDLE && w_next_state == BUSY_I) begin
        r_rw  <= bus.ICacheBusRW;
        r_adr <= bus.ICacheBusAdr;
      end else if (r_state == IDLE && w_next_state == BUSY_D) begin
        r_rw  <= bus.DCacheBusRW;
        r_adr <= bus.DCacheBusAdr;
      end else if (r_state != IDLE && bus.BusAck) begin
        r_rw  <= 2'b00;
        r_adr <= {PA_BITS{1'b0}};
      end
    end
  end

  assign bus.BusRW        = r_rw;
  assign bus.BusAdr       = r_adr;
  assign bus.GrantI       = w_grant_i;
  assign bus.GrantD       = w_grant_d;
  assign bus.ICacheBusAck = w_ack_i;
  assign bus.DCacheBusAck = w_ack_d;
  assign bus.ArbConflict  = w_conflict;

  a_grant_exclusive: assert property (@(posedge clk) disable iff (reset) !(w_grant_i && w_grant_d));

endmodule
